key_angle_stepper: RTL and testbench
====================================

Name: key_angle_stepper

Overview:
- Consumes the debounced outputs (one-cycle flag pulse + level state, state 0 = pressed) of two key debouncers: UP and DOWN.
- Converts press/hold into step pulses: one step on press, auto-repeat after a long hold.
- Accumulates the steps into a wrapping angle register that feeds the CORDIC angle input.
- Sits directly downstream of the key debouncers and upstream of the CORDIC core.

Parameters:
- HOLD_CYC, 25_000_000, cycles a key must stay pressed after its press event before auto-repeat starts (500 ms at 50 MHz).
- REPEAT_CYC, 5_000_000, cycles between auto-repeat steps (100 ms at 50 MHz).
- ANGLE_W, 9, width of the angle output.
- ANGLE_MAX, 359, largest angle value; the range is 0..ANGLE_MAX.
- STEP, 1, increment or decrement applied per step. Must satisfy 1 <= STEP <= ANGLE_MAX.

Ports:
- clk, input, 1: system clock (50 MHz).
- rst_n, input, 1: asynchronous active-low reset.
- up_flag, input, 1: one-cycle pulse from the UP debouncer at each debounced edge.
- up_state, input, 1: debounced UP level (0 = pressed, 1 = released).
- dn_flag, input, 1: one-cycle pulse from the DOWN debouncer.
- dn_state, input, 1: debounced DOWN level (0 = pressed).
- angle, output, ANGLE_W: current angle, registered.
- angle_valid, output, 1: one-cycle pulse in the cycle that angle takes a new value.
- up_long, output, 1: high while the UP channel is in REPEAT.
- dn_long, output, 1: high while the DOWN channel is in REPEAT.

Behaviour:
- Reset values: angle = 0, angle_valid = 0, up_long = 0, dn_long = 0. Both channel FSMs go to IDLE and all counters clear. Reset may assert at any time, including mid-hold, and takes effect immediately.
- Event decode per channel:
  - press = flag & ~state
  - release = flag & state
  - flag low: no event; state is ignored.
- Channel FSM states: IDLE, HOLD, REPEAT, plus a cycle counter wide enough for max(HOLD_CYC, REPEAT_CYC).
- IDLE: on press, go to HOLD, clear the counter, assert step.
- HOLD: on release, go to IDLE with no step. Otherwise, when the counter reaches HOLD_CYC-1, go to REPEAT, clear the counter, assert step. Otherwise increment the counter.
- REPEAT: on release, go to IDLE with no step. Otherwise, when the counter reaches REPEAT_CYC-1, clear the counter and assert step. Otherwise increment the counter.
- Event precedence:
  - A press while in HOLD or REPEAT is ignored.
  - A release while in IDLE is ignored.
  - A release in the same cycle as a counter terminal count wins: no step is produced.
- step is a registered one-cycle pulse. A press at cycle N gives step high at cycle N+1.
- Angle update happens one cycle after a step, so a press at cycle N gives angle updated and angle_valid high at cycle N+2.
- Arithmetic, with the step pulse from the prior cycle:
  - up only: angle + STEP if angle + STEP <= ANGLE_MAX, else angle + STEP - (ANGLE_MAX+1) (wrap).
  - dn only: angle - STEP if angle >= STEP, else angle + (ANGLE_MAX+1) - STEP (wrap).
  - Compute in ANGLE_W+1 bits; no overflow for legal parameters.
- Both channels stepping in the same cycle: they cancel. angle is unchanged and angle_valid stays 0.
- The two channels are independent. Holding both keys lets each run its own timing; only coincident steps cancel.
- up_long / dn_long are registered and high exactly while the channel is in REPEAT.
- Unreachable FSM encodings recover to IDLE with the counter cleared.

Decomposition:
- Shared package holds:
  - the channel state encoding (one-hot IDLE/HOLD/REPEAT);
  - default timing constants for 50 MHz (HOLD_CYC, REPEAT_CYC);
  - the angle range constants (ANGLE_W, ANGLE_MAX).
- One sub-module, key_repeat_ch, instantiated twice. It contains event decode, FSM, counter and step/long registers, with ports clk, rst_n, flag, state, step, long.
- The top level holds only the angle accumulator, the cancel logic and angle_valid.

Test Plan:
Bench parameters for all scenarios: HOLD_CYC=10, REPEAT_CYC=4, ANGLE_MAX=359, STEP=1.
1. Reset, then a single UP press pulse at cycle 5 and release at cycle 8 -> angle 0->1 at cycle 7, angle_valid high only at cycle 7, up_long never asserts.
2. UP press held 30 cycles -> angle_valid at press+2, press+12, press+16, press+20, press+24, press+28; up_long high from press+11 until release+1.
3. Wrap: from angle=359 an UP press gives angle=0. From angle=0 a DOWN press gives 359. Use STEP=5 from angle=357 -> 2.
4. UP and DOWN press pulses in the same cycle from angle=100 -> angle stays 100, no angle_valid; each channel still enters HOLD.
5. Release coincident with HOLD terminal count (press, release at press+10) -> only the initial step; no second step; up_long stays 0.
6. rst_n asserted mid-REPEAT at angle=42 -> angle=0, up_long=0 immediately. After deassert, no step occurs until a new press pulse, even if up_state is still 0.

Source files
------------

// File: rtl/key_angle_stepper_pkg.sv
// Shared types and defaults for the key-driven angle stepper.
// Timing defaults assume a 50 MHz system clock.
package key_angle_stepper_pkg;

    typedef enum logic [2:0] {
        CH_IDLE   = 3'b001,
        CH_HOLD   = 3'b010,
        CH_REPEAT = 3'b100
    } ch_state_e;

    localparam int HOLD_CYC_DEF   = 25_000_000;
    localparam int REPEAT_CYC_DEF = 5_000_000;
    localparam int ANGLE_W_DEF    = 9;
    localparam int ANGLE_MAX_DEF  = 359;
    localparam int STEP_DEF       = 1;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/key_repeat_ch.sv
// One key channel: press/release decode, hold timer and
// auto-repeat, producing registered step and long flags.
module key_repeat_ch
    import key_angle_stepper_pkg::*;
#(
    parameter int HOLD_CYC   = HOLD_CYC_DEF,
    parameter int REPEAT_CYC = REPEAT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flag,
    input  logic state,
    output logic step,
    output logic long
);

    localparam int CW = cnt_width(HOLD_CYC, REPEAT_CYC);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);

    ch_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_q, step_d;
    logic          long_q, long_d;
    logic          press_ev, rel_ev;

    assign press_ev = flag & ~state;
    assign rel_ev   = flag &  state;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        case (state_q)
            CH_IDLE: begin
                if (press_ev) begin
                    state_d = CH_HOLD;
                    cnt_d   = '0;
                    step_d  = 1'b1;
                end
            end
            CH_HOLD: begin
                if (rel_ev) begin
                    state_d = CH_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = CH_REPEAT;
                    cnt_d   = '0;
                    step_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CH_REPEAT: begin
                // release beats a coincident terminal count
                if (rel_ev) begin
                    state_d = CH_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d  = '0;
                    step_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = CH_IDLE;
                cnt_d   = '0;
            end
        endcase
        long_d = (state_d == CH_REPEAT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            long_q  <= long_d;
        end
    end

    assign step = step_q;
    assign long = long_q;

endmodule

// File: rtl/key_angle_stepper.sv
// Turns UP/DOWN key steps into a wrapping angle for the CORDIC.
// Coincident up and down steps cancel out.
module key_angle_stepper
    import key_angle_stepper_pkg::*;
#(
    parameter int HOLD_CYC   = HOLD_CYC_DEF,
    parameter int REPEAT_CYC = REPEAT_CYC_DEF,
    parameter int ANGLE_W    = ANGLE_W_DEF,
    parameter int ANGLE_MAX  = ANGLE_MAX_DEF,
    parameter int STEP       = STEP_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               up_flag,
    input  logic               up_state,
    input  logic               dn_flag,
    input  logic               dn_state,
    output logic [ANGLE_W-1:0] angle,
    output logic               angle_valid,
    output logic               up_long,
    output logic               dn_long
);

    localparam int XW = ANGLE_W + 1;
    localparam logic [XW-1:0] STEP_X = XW'(STEP);
    localparam logic [XW-1:0] MAX_X  = XW'(ANGLE_MAX);
    localparam logic [XW-1:0] MOD_X  = XW'(ANGLE_MAX + 1);

    logic               up_step, dn_step;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic               valid_q, valid_d;
    logic [XW-1:0]      ext, up_sum, nxt;
    logic               unused_msb;

    key_repeat_ch #(
        .HOLD_CYC  (HOLD_CYC),
        .REPEAT_CYC(REPEAT_CYC)
    ) u_up (
        .clk  (clk),
        .rst_n(rst_n),
        .flag (up_flag),
        .state(up_state),
        .step (up_step),
        .long (up_long)
    );

    key_repeat_ch #(
        .HOLD_CYC  (HOLD_CYC),
        .REPEAT_CYC(REPEAT_CYC)
    ) u_dn (
        .clk  (clk),
        .rst_n(rst_n),
        .flag (dn_flag),
        .state(dn_state),
        .step (dn_step),
        .long (dn_long)
    );

    always_comb begin
        ext     = {1'b0, angle_q};
        up_sum  = ext + STEP_X;
        nxt     = ext;
        valid_d = 1'b0;
        if (up_step && !dn_step) begin
            valid_d = 1'b1;
            nxt = (up_sum <= MAX_X) ? up_sum : up_sum - MOD_X;
        end else if (dn_step && !up_step) begin
            valid_d = 1'b1;
            nxt = (ext >= STEP_X) ? ext - STEP_X
                                  : ext + MOD_X - STEP_X;
        end
        angle_d = nxt[ANGLE_W-1:0];
    end

    assign unused_msb = nxt[XW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle_q <= '0;
            valid_q <= 1'b0;
        end else begin
            angle_q <= angle_d;
            valid_q <= valid_d;
        end
    end

    assign angle       = angle_q;
    assign angle_valid = valid_q;

endmodule

// File: tb/tb_key_angle_stepper.sv
// Bench for key_angle_stepper: elapsed-time model of both channels,
// directed scenarios, then random key activity with resets.
module tb_key_angle_stepper;

    localparam int H = 10;
    localparam int R = 4;
    localparam int M = 360;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up_flag = 1'b0, up_state = 1'b1;
    logic       dn_flag = 1'b0, dn_state = 1'b1;
    logic [8:0] angle, angle5;
    logic       angle_valid, valid5;
    logic       up_long, dn_long, up_long5, dn_long5;

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    bit  cmp_en = 0;
    int  vq[$];

    // model state
    int  m_ang[2];
    bit  m_vld;
    bit  m_stp[2];
    bit  act[2];
    int  pc[2];
    bit  lng[2];

    key_angle_stepper #(
        .HOLD_CYC(H), .REPEAT_CYC(R), .ANGLE_W(9),
        .ANGLE_MAX(359), .STEP(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .up_flag(up_flag), .up_state(up_state),
        .dn_flag(dn_flag), .dn_state(dn_state),
        .angle(angle), .angle_valid(angle_valid),
        .up_long(up_long), .dn_long(dn_long)
    );

    key_angle_stepper #(
        .HOLD_CYC(H), .REPEAT_CYC(R), .ANGLE_W(9),
        .ANGLE_MAX(359), .STEP(5)
    ) dut5 (
        .clk(clk), .rst_n(rst_n),
        .up_flag(up_flag), .up_state(up_state),
        .dn_flag(dn_flag), .dn_state(dn_state),
        .angle(angle5), .angle_valid(valid5),
        .up_long(up_long5), .dn_long(dn_long5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act_v, input int exp_v);
        n_vec++;
        if (act_v != exp_v) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d",
                     nm, cyc, act_v, exp_v);
        end
    endtask

    function automatic bit chan(input int i, input bit f, input bit s, input int c);
        bit st;
        st = 0;
        if (!act[i]) begin
            if (f && !s) begin
                act[i] = 1;
                pc[i] = c;
                st = 1;
            end
        end else if (f && s) begin
            act[i] = 0;
        end else if (c - pc[i] >= H && (c - pc[i] - H) % R == 0) begin
            st = 1;
        end
        lng[i] = act[i] && (c - pc[i] >= H);
        return st;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ang = '{0, 0};
            m_vld = 0;
            m_stp = '{0, 0};
            act = '{0, 0};
            lng = '{0, 0};
        end else begin
            int d;
            bit su, sd;
            d = int'(m_stp[0]) - int'(m_stp[1]);
            m_vld = (d != 0);
            m_ang[0] = (m_ang[0] + d * 1 + M) % M;
            m_ang[1] = (m_ang[1] + d * 5 + M) % M;
            su = chan(0, up_flag, up_state, cyc);
            sd = chan(1, dn_flag, dn_state, cyc);
            m_stp[0] = su;
            m_stp[1] = sd;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("angle", int'(angle), m_ang[0]);
            chk("valid", int'(angle_valid), int'(m_vld));
            chk("up_long", int'(up_long), int'(lng[0]));
            chk("dn_long", int'(dn_long), int'(lng[1]));
            chk("angle5", int'(angle5), m_ang[1]);
            chk("valid5", int'(valid5), int'(m_vld));
            chk("up_long5", int'(up_long5), int'(lng[0]));
            chk("dn_long5", int'(dn_long5), int'(lng[1]));
        end
        if (angle_valid) vq.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic at(input int c);
        while (cyc < c) tick();
    endtask

    // ch: 0 up, 1 down, 2 both; one-cycle flag pulse
    task automatic ev(input int ch, input bit st);
        if (ch != 1) begin
            up_flag = 1;
            up_state = st;
        end
        if (ch != 0) begin
            dn_flag = 1;
            dn_state = st;
        end
        tick();
        up_flag = 0;
        dn_flag = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        chk("rst_angle", int'(angle), 0);
        chk("rst_valid", int'(angle_valid), 0);
        chk("rst_up_long", int'(up_long), 0);
        chk("rst_dn_long", int'(dn_long), 0);
        ticks(2);
        rst_n = 1;
        tick();
    endtask

    initial begin
        int p;
        int exp2[6];
        exp2 = '{2, 12, 16, 20, 24, 28};
        tick();
        do_reset();
        cmp_en = 1;

        // single tap
        ticks(2);
        p = cyc;
        ev(0, 0);
        #1 chk("s1_valid_p1", int'(angle_valid), 0);
        at(p + 2);
        #1 chk("s1_angle_p2", int'(angle), 1);
        chk("s1_valid_p2", int'(angle_valid), 1);
        at(p + 3);
        ev(0, 1);
        #1 chk("s1_valid_p4", int'(angle_valid), 0);
        chk("s1_up_long", int'(up_long), 0);

        // 30-cycle hold
        ticks(3);
        vq.delete();
        p = cyc;
        ev(0, 0);
        at(p + 10);
        #1 chk("s2_long_p10", int'(up_long), 0);
        at(p + 11);
        #1 chk("s2_long_p11", int'(up_long), 1);
        at(p + 30);
        #1 chk("s2_long_p30", int'(up_long), 1);
        ev(0, 1);
        #1 chk("s2_long_p31", int'(up_long), 0);
        ticks(3);
        chk("s2_nvalid", vq.size(), 6);
        for (int i = 0; i < 6 && i < vq.size(); i++)
            chk("s2_valid_ofs", vq[i] - p, exp2[i]);
        chk("s2_angle", int'(angle), 7);
        chk("s2_angle5", int'(angle5), 35);

        // release on hold terminal count
        vq.delete();
        p = cyc;
        ev(0, 0);
        at(p + 10);
        ev(0, 1);
        #1 chk("s5_long", int'(up_long), 0);
        ticks(4);
        chk("s5_nvalid", vq.size(), 1);
        chk("s5_angle", int'(angle), 8);

        // coincident presses cancel, both channels still time out
        vq.delete();
        p = cyc;
        ev(2, 0);
        at(p + 11);
        #1 chk("s4_up_long", int'(up_long), 1);
        chk("s4_dn_long", int'(dn_long), 1);
        at(p + 14);
        ev(2, 1);
        ticks(3);
        chk("s4_nvalid", vq.size(), 0);
        chk("s4_angle", int'(angle), 8);
        chk("s4_angle5", int'(angle5), 40);

        // wrap in both directions
        do_reset();
        p = cyc;
        ev(1, 0);
        at(p + 2);
        #1 chk("s3_dn_wrap", int'(angle), 359);
        chk("s3_dn_wrap5", int'(angle5), 355);
        ev(1, 1);
        ticks(2);
        p = cyc;
        ev(0, 0);
        at(p + 2);
        #1 chk("s3_up_wrap", int'(angle), 0);
        chk("s3_up_wrap5", int'(angle5), 0);
        ev(0, 1);
        ticks(2);

        // reset mid-repeat while key stays down
        p = cyc;
        ev(0, 0);
        at(p + 16);
        #1 chk("s6_pre_angle", int'(angle), 3);
        chk("s6_pre_long", int'(up_long), 1);
        rst_n = 0;
        #1 chk("s6_rst_angle", int'(angle), 0);
        chk("s6_rst_long", int'(up_long), 0);
        vq.delete();
        tick();
        rst_n = 1;
        ticks(20);
        chk("s6_no_step", vq.size(), 0);
        chk("s6_angle", int'(angle), 0);
        p = cyc;
        ev(0, 0);
        at(p + 2);
        #1 chk("s6_new_press", int'(angle), 1);
        ev(0, 1);

        // random key activity
        for (int i = 0; i < 3000; i++) begin
            int div;
            div = (i < 1000) ? 6 : 40;
            up_flag = ($urandom_range(div - 1) == 0);
            if (up_flag) up_state = 1'($urandom_range(1));
            dn_flag = ($urandom_range(div - 1) == 0);
            if (dn_flag) dn_state = 1'($urandom_range(1));
            rst_n = ($urandom_range(599) != 0);
            tick();
        end
        up_flag = 0;
        dn_flag = 0;
        rst_n = 1;
        ticks(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
